// File: rtl/cbsel_arb.sv
// Round-robin 4-way arbiter driving cbsel one-hot select; optional grant timeout via CBSEL_ARB_TIMEOUT_EN.
// Latency: 1 cycle req->sel/o_data/o_valid; back-to-back grants at 1 transfer/cycle.
// Backpressure: o_ready low holds sel/o_data/o_valid stable (dropped after HOLD_MAX cycles when timeout enabled).
module cbsel_arb #(
    parameter int W        = 10,
    parameter int HOLD_MAX = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [W-1:0] i0,
    input  logic [W-1:0] i1,
    input  logic [W-1:0] i2,
    input  logic [W-1:0] i3,
    output logic [3:0]   sel,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [3:0]   ack,
    output logic         busy,
    output logic         timeout_err
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state_q, state_d;
    logic [1:0]     ptr_q, ptr_d;
    logic [1:0]     win_q, win_d;
    logic [3:0]     sel_q, sel_d;
    logic [3:0]     ack_q, ack_d;
    logic [W-1:0]   data_q, data_d;
    logic           valid_q, valid_d;
    logic           hs;

    logic [1:0]     arb_base;
    logic [3:0]     arb_req;
    logic [1:0]     arb_cand;
    logic [1:0]     arb_idx;
    logic           arb_vld;
    logic [W-1:0]   arb_opnd;

`ifdef CBSEL_ARB_TIMEOUT_EN
    logic [3:0]     cnt_q, cnt_d;
    logic           terr_q, terr_d;
`endif

    assign hs = valid_q & o_ready;

    // While granted, the search starts after the current winner, which is also masked out.
    always_comb begin
        arb_base = (state_q == GRANT) ? win_q : ptr_q;
        arb_req  = req;
        if (state_q == GRANT) begin
            arb_req[win_q] = 1'b0;
        end
        arb_idx  = arb_base;
        arb_vld  = 1'b0;
        arb_cand = arb_base;
        for (int i = 4; i >= 1; i--) begin
            arb_cand = arb_base + 2'(i);
            if (arb_req[arb_cand]) begin
                arb_idx = arb_cand;
                arb_vld = 1'b1;
            end
        end
    end

    always_comb begin
        case (arb_idx)
            2'd0:    arb_opnd = i0;
            2'd1:    arb_opnd = i1;
            2'd2:    arb_opnd = i2;
            default: arb_opnd = i3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        sel_d   = sel_q;
        data_d  = data_q;
        valid_d = valid_q;
        ack_d   = 4'b0000;
`ifdef CBSEL_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        terr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    sel_d   = 4'b0001 << arb_idx;
                    data_d  = arb_opnd;
                    valid_d = 1'b1;
                    win_d   = arb_idx;
                    state_d = GRANT;
`ifdef CBSEL_ARB_TIMEOUT_EN
                    cnt_d   = 4'd0;
`endif
                end
            end
            GRANT: begin
                if (hs) begin
                    ack_d = sel_q;
                    ptr_d = win_q;
                    if (arb_vld) begin
                        sel_d  = 4'b0001 << arb_idx;
                        data_d = arb_opnd;
                        win_d  = arb_idx;
`ifdef CBSEL_ARB_TIMEOUT_EN
                        cnt_d  = 4'd0;
`endif
                    end else begin
                        sel_d   = 4'b0000;
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
`ifdef CBSEL_ARB_TIMEOUT_EN
                // Counter would reach HOLD_MAX this edge: abandon the grant without an ack.
                else if (cnt_q + 4'd1 == 4'(HOLD_MAX)) begin
                    sel_d   = 4'b0000;
                    valid_d = 1'b0;
                    terr_d  = 1'b1;
                    ptr_d   = win_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd3;
            win_q   <= 2'd0;
            sel_q   <= 4'b0000;
            ack_q   <= 4'b0000;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

`ifdef CBSEL_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 4'd0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
        end
    end
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign sel     = sel_q;
    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign ack     = ack_q;
    assign busy    = (state_q == GRANT);

endmodule

// File: tb/tb_cbsel_arb.sv
// Self-checking bench for cbsel_arb: scoreboard of expected grants popped on each handshake.
module tb_cbsel_arb;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req = 4'b0000;
    logic [W-1:0] i0 = '0, i1 = '0, i2 = '0, i3 = '0;
    logic [3:0]   sel;
    logic [W-1:0] o_data;
    logic         o_valid;
    logic         o_ready = 1'b0;
    logic [3:0]   ack;
    logic         busy;
    logic         timeout_err;

    typedef struct {
        logic [3:0]   sel;
        logic [W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    cbsel_arb #(.W(W), .HOLD_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .i0(i0), .i1(i1), .i2(i2), .i3(i3),
        .sel(sel), .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready),
        .ack(ack), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [3:0] s, input logic [W-1:0] d);
        exp_t e;
        e.sel  = s;
        e.data = d;
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; req = 4'b0000; o_ready = 1'b0;
        #12;
        total++;
        if ({sel, o_data, o_valid, ack, busy, timeout_err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs sel=%b o_data=%0d o_valid=%b ack=%b busy=%b terr=%b (want all 0)",
                     sel, o_data, o_valid, ack, busy, timeout_err);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (sel !== 4'b0000 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_idle sel=%b busy=%b want 0000/0", sel, busy);
        end
    endtask

    task automatic test_single();
        exp_t e; logic [3:0] exp_ack; int got;
        i3 = 10'd140; req = 4'b1000; o_ready = 1'b1;
        exp_q.push_back(mk(4'b1000, 10'd140));
        exp_ack = 4'b0000; got = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++;
            if (ack !== exp_ack) begin bad++; $display("FAIL single_ack c=%0d got=%b want=%b", c, ack, exp_ack); end
            if (c == 0) begin
                total++;
                if (o_valid !== 1'b1) begin bad++; $display("FAIL single_latency o_valid=%b want 1", o_valid); end
            end
            if (c == 1) begin
                total++;
                if (sel !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL single_idle sel=%b busy=%b want 0000/0", sel, busy); end
            end
            req = req & ~ack;
            exp_ack = 4'b0000;
            if (o_valid && o_ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL single_extra sel=%b o_data=%0d want none", sel, o_data); end
                else begin
                    e = exp_q.pop_front(); exp_ack = e.sel; got++;
                    if (sel !== e.sel || o_data !== e.data) begin
                        bad++; $display("FAIL single_xfer sel=%b o_data=%0d want %b/%0d", sel, o_data, e.sel, e.data);
                    end
                end
            end
        end
        total++;
        if (got != 1) begin bad++; $display("FAIL single_count got=%0d want 1", got); end
    endtask

    task automatic test_all();
        exp_t e; logic [3:0] exp_ack; int got;
        i0 = 10'd18; i1 = 10'd12; i2 = 10'd15; i3 = 10'd140;
        req = 4'b1111; o_ready = 1'b1;
        exp_q.push_back(mk(4'b0001, 10'd18));
        exp_q.push_back(mk(4'b0010, 10'd12));
        exp_q.push_back(mk(4'b0100, 10'd15));
        exp_q.push_back(mk(4'b1000, 10'd140));
        exp_ack = 4'b0000; got = 0;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            total++;
            if (ack !== exp_ack) begin bad++; $display("FAIL all_ack c=%0d got=%b want=%b", c, ack, exp_ack); end
            if (c < 4) begin
                total++;
                if (o_valid !== 1'b1) begin bad++; $display("FAIL all_throughput c=%0d o_valid=%b want 1", c, o_valid); end
            end
            req = req & ~ack;
            exp_ack = 4'b0000;
            if (o_valid && o_ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL all_extra sel=%b o_data=%0d want none", sel, o_data); end
                else begin
                    e = exp_q.pop_front(); exp_ack = e.sel; got++;
                    if (sel !== e.sel || o_data !== e.data) begin
                        bad++; $display("FAIL all_xfer c=%0d sel=%b o_data=%0d want %b/%0d", c, sel, o_data, e.sel, e.data);
                    end
                end
            end
        end
        total++;
        if (got != 4) begin bad++; $display("FAIL all_count got=%0d want 4", got); end
    endtask

    task automatic test_backpressure();
        exp_t e; logic [3:0] exp_ack; int got;
        i2 = 10'd15; req = 4'b0100; o_ready = 1'b0;
        exp_q.push_back(mk(4'b0100, 10'd15));
        exp_ack = 4'b0000; got = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            total++;
            if (ack !== exp_ack) begin bad++; $display("FAIL bp_ack c=%0d got=%b want=%b", c, ack, exp_ack); end
            if (c < 5) begin
                total++;
                if (o_valid !== 1'b1 || o_data !== 10'd15 || sel !== 4'b0100) begin
                    bad++; $display("FAIL bp_hold c=%0d o_valid=%b o_data=%0d sel=%b want 1/15/0100", c, o_valid, o_data, sel);
                end
            end
            if (c == 4) o_ready = 1'b1;
            req = req & ~ack;
            exp_ack = 4'b0000;
            if (o_valid && o_ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL bp_extra sel=%b want none", sel); end
                else begin
                    e = exp_q.pop_front(); exp_ack = e.sel; got++;
                    if (c != 4 || sel !== e.sel || o_data !== e.data) begin
                        bad++; $display("FAIL bp_xfer c=%0d sel=%b o_data=%0d want c=4 %b/%0d", c, sel, o_data, e.sel, e.data);
                    end
                end
            end
        end
        total++;
        if (got != 1) begin bad++; $display("FAIL bp_count got=%0d want 1", got); end
    endtask

    task automatic test_fairness();
        exp_t e; logic [3:0] exp_ack; logic [3:0] prev_sel; int got;
        i0 = 10'd18; i1 = 10'd12; req = 4'b0011; o_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) exp_q.push_back(mk(4'b0001, 10'd18));
            else            exp_q.push_back(mk(4'b0010, 10'd12));
        end
        exp_ack = 4'b0000; prev_sel = 4'b0000; got = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            total++;
            if (ack !== exp_ack) begin bad++; $display("FAIL fair_ack c=%0d got=%b want=%b", c, ack, exp_ack); end
            if (c == 5) req = 4'b0000;
            exp_ack = 4'b0000;
            if (o_valid && o_ready) begin
                total++;
                if (sel === prev_sel) begin bad++; $display("FAIL fair_repeat c=%0d sel=%b prev=%b", c, sel, prev_sel); end
                prev_sel = sel;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL fair_extra sel=%b want none", sel); end
                else begin
                    e = exp_q.pop_front(); exp_ack = e.sel; got++;
                    if (sel !== e.sel || o_data !== e.data) begin
                        bad++; $display("FAIL fair_xfer c=%0d sel=%b o_data=%0d want %b/%0d", c, sel, o_data, e.sel, e.data);
                    end
                end
            end
        end
        total++;
        if (got != 6) begin bad++; $display("FAIL fair_count got=%0d want 6", got); end
    endtask

    task automatic test_reset_mid_grant();
        i1 = 10'd12; req = 4'b0010; o_ready = 1'b0;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b1 || sel !== 4'b0010) begin bad++; $display("FAIL rstmid_grant busy=%b sel=%b want 1/0010", busy, sel); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({sel, o_data, o_valid, ack, busy, timeout_err} !== '0) begin
            bad++;
            $display("FAIL rstmid_async sel=%b o_data=%0d o_valid=%b ack=%b busy=%b terr=%b (want all 0)",
                     sel, o_data, o_valid, ack, busy, timeout_err);
        end
        req = 4'b0000;
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++;
            if (ack !== 4'b0000) begin bad++; $display("FAIL rstmid_noack c=%0d ack=%b want 0000", c, ack); end
        end
        i0 = 10'd18; i2 = 10'd15; req = 4'b0101;
        @(posedge clk); #1;
        total++;
        if (sel !== 4'b0001 || o_data !== 10'd18) begin
            bad++; $display("FAIL rstmid_priority sel=%b o_data=%0d want 0001/18", sel, o_data);
        end
        req = 4'b0000;
        #2 rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_timeout();
        logic terr_seen;
        i1 = 10'd12; req = 4'b0010; o_ready = 1'b0;
`ifdef CBSEL_ARB_TIMEOUT_EN
        for (int c = 0; c < 17; c++) begin
            @(posedge clk); #1;
            if (c < 15) begin
                total++;
                if (o_valid !== 1'b1 || timeout_err !== 1'b0) begin
                    bad++; $display("FAIL to_hold c=%0d o_valid=%b terr=%b want 1/0", c, o_valid, timeout_err);
                end
            end else if (c == 15) begin
                total++;
                if (o_valid !== 1'b0 || timeout_err !== 1'b1 || ack !== 4'b0000 || sel !== 4'b0000) begin
                    bad++; $display("FAIL to_drop o_valid=%b terr=%b ack=%b sel=%b want 0/1/0000/0000", o_valid, timeout_err, ack, sel);
                end
            end else begin
                total++;
                if (o_valid !== 1'b1 || timeout_err !== 1'b0 || sel !== 4'b0010) begin
                    bad++; $display("FAIL to_regrant o_valid=%b terr=%b sel=%b want 1/0/0010", o_valid, timeout_err, sel);
                end
            end
        end
`else
        terr_seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (timeout_err !== 1'b0 || ack !== 4'b0000) terr_seen = 1'b1;
        end
        total++;
        if (terr_seen !== 1'b0) begin bad++; $display("FAIL to_off_pulse saw timeout_err/ack activity, want none"); end
        total++;
        if (o_valid !== 1'b1 || sel !== 4'b0010 || o_data !== 10'd12) begin
            bad++; $display("FAIL to_off_held o_valid=%b sel=%b o_data=%0d want 1/0010/12", o_valid, sel, o_data);
        end
`endif
        req = 4'b0000;
        #2 rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all();
        test_backpressure();
        test_fairness();
        test_reset_mid_grant();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
